// File: rtl/inst_fetch_prefetch_pkg.sv
// Shared types and defaults for the instruction fetch/prefetch stage.
// Redirect source encoding and the default ISR slot size live here.
package inst_fetch_prefetch_pkg;

    typedef enum logic [1:0] {
        RdrNone = 2'd0,
        RdrIrq  = 2'd1,
        RdrEx   = 2'd2,
        RdrBpu  = 2'd3
    } redirect_e;

    localparam int unsigned IsrShiftDefault = 3;

    // Width of a counter that must hold the values 0..n inclusive.
    function automatic int unsigned count_width(input int unsigned n);
        return $clog2(n) + 1;
    endfunction

endpackage

// File: rtl/inst_fetch_prefetch_fifo.sv
// First-word-fall-through prefetch FIFO with a synchronous clear.
// Holds {instruction, pc} pairs; the head is visible whenever the FIFO is non-empty.
module inst_fetch_prefetch_fifo
    import inst_fetch_prefetch_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 64
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clear,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     pop,
    output logic                     empty,
    output logic [WIDTH-1:0]         rdata,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned CntW = count_width(DEPTH);
    localparam logic [CntW-1:0] FullCount = CntW'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PtrW-1:0]  rd_ptr_q;
    logic [PtrW-1:0]  wr_ptr_q;
    logic [CntW-1:0]  count_q;
    logic             do_push;
    logic             do_pop;

    assign do_pop  = pop & (count_q != '0);
    // A push into a full FIFO is only legal when the head leaves in the same cycle.
    assign do_push = push & ((count_q != FullCount) | do_pop);

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + PtrW'(1);
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + PtrW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + CntW'(1);
                2'b01:   count_q <= count_q - CntW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !clear && !rst) begin
            mem_q[wr_ptr_q] <= wdata;
        end
    end

    assign empty = (count_q == '0);
    assign rdata = mem_q[rd_ptr_q];
    assign count = count_q;

endmodule

// File: rtl/inst_fetch_prefetch.sv
// Fetch stage: PC generation, pipelined imem requests, prefetch buffering and redirect handling.
// Delivers {inst, pc, pc+4} to IF_ID under a valid/ready handshake.
module inst_fetch_prefetch
    import inst_fetch_prefetch_pkg::*;
#(
    parameter int unsigned    XLEN      = 32,
    parameter int unsigned    DEPTH     = 4,
    parameter int unsigned    MAX_OUT   = 2,
    parameter logic [XLEN-1:0] RESET_PC = '0,
    parameter int unsigned    ISR_SHIFT = IsrShiftDefault
) (
    input  logic                   CLK,
    input  logic                   RST,
    input  logic                   PC_Control__IRQ,
    input  logic [5:0]             Device_id,
    input  logic [XLEN-1:0]        CSR_mtvec,
    input  logic                   Branch_Taken__EX_MEM,
    input  logic [XLEN-1:0]        Branch_Target_Addr__EX_MEM,
    input  logic                   BPU__Branch_Taken,
    input  logic [XLEN-1:0]        BPU__Branch_Target_Addr,
    output logic                   IMem_Req_Valid,
    input  logic                   IMem_Req_Ready,
    output logic [XLEN-1:0]        IMem_Req_Addr,
    input  logic                   IMem_Rsp_Valid,
    input  logic [31:0]            IMem_Rsp_Data,
    output logic                   Inst_Valid__IF_ID,
    input  logic                   Inst_Ready__IF_ID,
    output logic [31:0]            Inst__IF_ID,
    output logic [XLEN-1:0]        PC__IF_ID,
    output logic [XLEN-1:0]        PC_4__IF_ID,
    output logic [$clog2(DEPTH):0] Fifo_Count
);

    localparam int unsigned CntW = count_width(DEPTH);
    localparam int unsigned OutW = count_width(MAX_OUT);

    logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
    logic [XLEN-1:0] resp_pc_q, resp_pc_d;
    logic [OutW-1:0] outstanding_q, outstanding_d;
    logic [OutW-1:0] drop_cnt_q, drop_cnt_d;

    redirect_e       rdr_src;
    logic [XLEN-1:0] rdr_target;
    logic [XLEN-1:0] rdr_target_aligned;
    logic [XLEN-1:0] isr_vector;
    logic            redirect;
    logic            head_valid;
    logic            inst_pop;
    logic            req_fire;
    logic            rsp_push;
    logic [31:0]     in_use;

    logic [CntW-1:0]      fifo_count;
    logic [XLEN+31:0]     fifo_wdata;
    logic [XLEN+31:0]     fifo_rdata;
    logic                 fifo_empty;
    logic [31:0]          head_inst;
    logic [XLEN-1:0]      head_pc;

    assign isr_vector = CSR_mtvec + (XLEN'(Device_id) << ISR_SHIFT);

    assign head_valid        = ~fifo_empty;
    assign Inst_Valid__IF_ID = head_valid & ~PC_Control__IRQ & ~Branch_Taken__EX_MEM;
    assign inst_pop          = Inst_Valid__IF_ID & Inst_Ready__IF_ID;

    // BPU only redirects once the predicted entry has actually been handed to IF_ID.
    always_comb begin
        rdr_src    = RdrNone;
        rdr_target = '0;
        if (PC_Control__IRQ) begin
            rdr_src    = RdrIrq;
            rdr_target = isr_vector;
        end else if (Branch_Taken__EX_MEM) begin
            rdr_src    = RdrEx;
            rdr_target = Branch_Target_Addr__EX_MEM;
        end else if (BPU__Branch_Taken && inst_pop) begin
            rdr_src    = RdrBpu;
            rdr_target = BPU__Branch_Target_Addr;
        end
    end

    assign redirect           = (rdr_src != RdrNone);
    assign rdr_target_aligned = {rdr_target[XLEN-1:2], 2'b00};

    // Reserve FIFO space for every outstanding request so responses never overflow.
    assign in_use         = 32'(outstanding_q) + 32'(fifo_count);
    assign IMem_Req_Valid = ~RST & ~redirect & (in_use < DEPTH) & (32'(outstanding_q) < MAX_OUT);
    assign IMem_Req_Addr  = fetch_pc_q;
    assign req_fire       = IMem_Req_Valid & IMem_Req_Ready;

    assign rsp_push      = IMem_Rsp_Valid & ~redirect & (drop_cnt_q == '0);
    assign outstanding_d = outstanding_q + OutW'(req_fire) - OutW'(IMem_Rsp_Valid);

    always_comb begin
        fetch_pc_d = fetch_pc_q;
        resp_pc_d  = resp_pc_q;
        drop_cnt_d = drop_cnt_q;
        if (redirect) begin
            fetch_pc_d = rdr_target_aligned;
            resp_pc_d  = rdr_target_aligned;
            drop_cnt_d = outstanding_d;
        end else begin
            if (req_fire) begin
                fetch_pc_d = fetch_pc_q + XLEN'(4);
            end
            if (rsp_push) begin
                resp_pc_d = resp_pc_q + XLEN'(4);
            end
            if (IMem_Rsp_Valid && (drop_cnt_q != '0)) begin
                drop_cnt_d = drop_cnt_q - OutW'(1);
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            fetch_pc_q    <= RESET_PC;
            resp_pc_q     <= RESET_PC;
            outstanding_q <= '0;
            drop_cnt_q    <= '0;
        end else begin
            fetch_pc_q    <= fetch_pc_d;
            resp_pc_q     <= resp_pc_d;
            outstanding_q <= outstanding_d;
            drop_cnt_q    <= drop_cnt_d;
        end
    end

    assign fifo_wdata = {IMem_Rsp_Data, resp_pc_q};

    inst_fetch_prefetch_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (XLEN + 32)
    ) u_fifo (
        .clk   (CLK),
        .rst   (RST),
        .clear (redirect),
        .push  (rsp_push),
        .wdata (fifo_wdata),
        .pop   (inst_pop),
        .empty (fifo_empty),
        .rdata (fifo_rdata),
        .count (fifo_count)
    );

    assign head_inst = fifo_rdata[XLEN+31:XLEN];
    assign head_pc   = fifo_rdata[XLEN-1:0];

    // With nothing buffered the payload shows its reset-state values.
    assign Inst__IF_ID = head_valid ? head_inst : '0;
    assign PC__IF_ID   = head_valid ? head_pc : '0;
    assign PC_4__IF_ID = head_valid ? head_pc + XLEN'(4) : RESET_PC + XLEN'(4);
    assign Fifo_Count  = fifo_count;

endmodule

// File: tb/tb_inst_fetch_prefetch.sv
// Randomised bench for inst_fetch_prefetch: a behavioural imem plus a queue model of
// which fetched PCs must reach IF_ID, tagged by redirect epoch.
module tb_inst_fetch_prefetch;

    localparam int unsigned DEPTH     = 4;
    localparam int unsigned MAX_OUT   = 2;
    localparam int unsigned ISR_SHIFT = 3;
    localparam logic [31:0] RESET_PC  = 32'h0;

    logic        CLK = 1'b0;
    logic        RST;
    logic        PC_Control__IRQ;
    logic [5:0]  Device_id;
    logic [31:0] CSR_mtvec;
    logic        Branch_Taken__EX_MEM;
    logic [31:0] Branch_Target_Addr__EX_MEM;
    logic        BPU__Branch_Taken;
    logic [31:0] BPU__Branch_Target_Addr;
    logic        IMem_Req_Valid;
    logic        IMem_Req_Ready;
    logic [31:0] IMem_Req_Addr;
    logic        IMem_Rsp_Valid;
    logic [31:0] IMem_Rsp_Data;
    logic        Inst_Valid__IF_ID;
    logic        Inst_Ready__IF_ID;
    logic [31:0] Inst__IF_ID;
    logic [31:0] PC__IF_ID;
    logic [31:0] PC_4__IF_ID;
    logic [2:0]  Fifo_Count;

    inst_fetch_prefetch #(
        .XLEN      (32),
        .DEPTH     (DEPTH),
        .MAX_OUT   (MAX_OUT),
        .RESET_PC  (RESET_PC),
        .ISR_SHIFT (ISR_SHIFT)
    ) dut (
        .CLK                        (CLK),
        .RST                        (RST),
        .PC_Control__IRQ            (PC_Control__IRQ),
        .Device_id                  (Device_id),
        .CSR_mtvec                  (CSR_mtvec),
        .Branch_Taken__EX_MEM       (Branch_Taken__EX_MEM),
        .Branch_Target_Addr__EX_MEM (Branch_Target_Addr__EX_MEM),
        .BPU__Branch_Taken          (BPU__Branch_Taken),
        .BPU__Branch_Target_Addr    (BPU__Branch_Target_Addr),
        .IMem_Req_Valid             (IMem_Req_Valid),
        .IMem_Req_Ready             (IMem_Req_Ready),
        .IMem_Req_Addr              (IMem_Req_Addr),
        .IMem_Rsp_Valid             (IMem_Rsp_Valid),
        .IMem_Rsp_Data              (IMem_Rsp_Data),
        .Inst_Valid__IF_ID          (Inst_Valid__IF_ID),
        .Inst_Ready__IF_ID          (Inst_Ready__IF_ID),
        .Inst__IF_ID                (Inst__IF_ID),
        .PC__IF_ID                  (PC__IF_ID),
        .PC_4__IF_ID                (PC_4__IF_ID),
        .Fifo_Count                 (Fifo_Count)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [31:0] addr;
        int          epoch;
        int          due;
    } req_t;

    req_t        pend[$];     // requests the imem has accepted, oldest first
    logic [31:0] mq[$];       // PCs that should currently sit in the prefetch buffer
    int          epoch;
    int          cyc;
    int          lat_min;
    int          lat_max;
    logic [31:0] fetch_pc_m;

    int tests_run;
    int failed;

    bit          t_irq, t_ex, t_bpu, t_ready_if, t_ready_mem;
    logic [31:0] t_ex_tgt, t_bpu_tgt, t_mtvec;
    logic [5:0]  t_dev;

    bit          exp_valid, exp_req_valid, deliv, redir;
    int          exp_cnt;
    logic [31:0] exp_req_addr, exp_pc, exp_inst;
    bit          obs_valid, obs_req_valid;
    int          obs_cnt;
    logic [31:0] obs_req_addr, obs_pc, obs_pc4, obs_inst;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B9) ^ 32'h0000_0013;
    endfunction

    task automatic set_idle();
        t_irq = 0; t_ex = 0; t_bpu = 0; t_ready_if = 1; t_ready_mem = 1;
        t_ex_tgt = '0; t_bpu_tgt = '0; t_mtvec = '0; t_dev = '0;
        lat_min = 0; lat_max = 0;
    endtask

    // One clock: drive knobs, compute the model's view of this cycle, advance the model.
    task automatic tick();
        bit          bpu_take, rsp, fire;
        logic [31:0] tgt;
        req_t        r;
        @(negedge CLK);
        RST                        = 1'b0;
        PC_Control__IRQ            = t_irq;
        Branch_Taken__EX_MEM       = t_ex;
        Branch_Target_Addr__EX_MEM = t_ex_tgt;
        BPU__Branch_Taken          = t_bpu;
        BPU__Branch_Target_Addr    = t_bpu_tgt;
        CSR_mtvec                  = t_mtvec;
        Device_id                  = t_dev;
        Inst_Ready__IF_ID          = t_ready_if;
        IMem_Req_Ready             = t_ready_mem;
        rsp                        = (pend.size() > 0) && (pend[0].due <= cyc);
        IMem_Rsp_Valid             = rsp;
        IMem_Rsp_Data              = rsp ? mem_word(pend[0].addr) : $urandom;
        #1;
        obs_valid     = Inst_Valid__IF_ID;
        obs_req_valid = IMem_Req_Valid;
        obs_req_addr  = IMem_Req_Addr;
        obs_cnt       = int'(Fifo_Count);
        obs_pc        = PC__IF_ID;
        obs_pc4       = PC_4__IF_ID;
        obs_inst      = Inst__IF_ID;

        bpu_take      = t_bpu && (mq.size() > 0) && !t_irq && !t_ex && t_ready_if;
        redir         = t_irq || t_ex || bpu_take;
        tgt           = t_irq ? t_mtvec + ({26'd0, t_dev} << ISR_SHIFT) :
                        t_ex  ? t_ex_tgt : t_bpu_tgt;
        exp_valid     = (mq.size() > 0) && !t_irq && !t_ex;
        exp_cnt       = mq.size();
        exp_req_valid = !redir && (pend.size() + mq.size() < DEPTH) && (pend.size() < MAX_OUT);
        exp_req_addr  = fetch_pc_m;
        deliv         = exp_valid && t_ready_if;
        if (deliv) begin
            exp_pc   = mq[0];
            exp_inst = mem_word(mq[0]);
        end
        // The imem answers whatever the DUT really issued.
        fire = obs_req_valid && t_ready_mem;

        if (deliv) void'(mq.pop_front());
        if (rsp) begin
            r = pend.pop_front();
            if (!redir && r.epoch == epoch) mq.push_back(r.addr);
        end
        if (fire) pend.push_back('{addr: exp_req_addr, epoch: epoch,
                                   due: cyc + 1 + int'($urandom_range(lat_min, lat_max))});
        if (redir) begin
            mq.delete();
            epoch++;
            fetch_pc_m = tgt;
        end else if (exp_req_valid && t_ready_mem) begin
            fetch_pc_m = fetch_pc_m + 32'd4;
        end
        @(posedge CLK);
        cyc++;
    endtask

    // Ends #1 after a clock edge with RST still asserted; the next tick releases it.
    task automatic do_reset();
        @(negedge CLK);
        RST = 1'b1;
        PC_Control__IRQ = 0; Branch_Taken__EX_MEM = 0; BPU__Branch_Taken = 0;
        IMem_Req_Ready = 0; IMem_Rsp_Valid = 0; Inst_Ready__IF_ID = 0;
        @(posedge CLK);
        #1;
        pend.delete();
        mq.delete();
        epoch++;
        fetch_pc_m = RESET_PC;
    endtask

    task automatic test_reset();
        do_reset();
        tests_run++;
        if (Inst_Valid__IF_ID !== 1'b0 || Fifo_Count !== 3'd0 || IMem_Req_Valid !== 1'b0) begin
            failed++;
            $display("FAIL reset_flags: got valid=%b cnt=%0d req_valid=%b, want 0 0 0",
                     Inst_Valid__IF_ID, Fifo_Count, IMem_Req_Valid);
        end
        tests_run++;
        if (IMem_Req_Addr !== RESET_PC || PC_4__IF_ID !== RESET_PC + 32'd4) begin
            failed++;
            $display("FAIL reset_pc: got addr=%h pc4=%h, want %h %h",
                     IMem_Req_Addr, PC_4__IF_ID, RESET_PC, RESET_PC + 32'd4);
        end
        tests_run++;
        if (Inst__IF_ID !== 32'd0 || PC__IF_ID !== 32'd0) begin
            failed++;
            $display("FAIL reset_payload: got inst=%h pc=%h, want 0 0", Inst__IF_ID, PC__IF_ID);
        end
    endtask

    task automatic test_stream();
        int n_del = 0;
        set_idle();
        for (int i = 0; i < 30; i++) begin
            tick();
            tests_run++;
            if (obs_valid !== exp_valid || obs_cnt != exp_cnt) begin
                failed++;
                $display("FAIL stream_valid: got valid=%b cnt=%0d, want %b %0d",
                         obs_valid, obs_cnt, exp_valid, exp_cnt);
            end
            tests_run++;
            if (obs_req_valid !== exp_req_valid || obs_req_addr !== exp_req_addr) begin
                failed++;
                $display("FAIL stream_req: got valid=%b addr=%h, want %b %h",
                         obs_req_valid, obs_req_addr, exp_req_valid, exp_req_addr);
            end
            if (deliv) begin
                tests_run++;
                if (obs_pc !== exp_pc || obs_inst !== exp_inst || obs_pc4 !== exp_pc + 32'd4) begin
                    failed++;
                    $display("FAIL stream_data: got pc=%h inst=%h pc4=%h, want %h %h %h",
                             obs_pc, obs_inst, obs_pc4, exp_pc, exp_inst, exp_pc + 32'd4);
                end
                if (i >= 10) n_del++;
            end
        end
        tests_run++;
        if (n_del != 20) begin
            failed++;
            $display("FAIL stream_throughput: got %0d deliveries in 20 cycles, want 20", n_del);
        end
    endtask

    task automatic test_backpressure();
        set_idle();
        t_ready_if = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            tests_run++;
            if (obs_cnt != exp_cnt || obs_req_valid !== exp_req_valid) begin
                failed++;
                $display("FAIL stall_state: got cnt=%0d req_valid=%b, want %0d %b",
                         obs_cnt, obs_req_valid, exp_cnt, exp_req_valid);
            end
        end
        tests_run++;
        if (obs_cnt != 4 || obs_req_valid !== 1'b0) begin
            failed++;
            $display("FAIL stall_saturate: got cnt=%0d req_valid=%b, want 4 0",
                     obs_cnt, obs_req_valid);
        end
        t_ready_if = 1;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (deliv) begin
                tests_run++;
                if (obs_valid !== 1'b1 || obs_pc !== exp_pc || obs_inst !== exp_inst) begin
                    failed++;
                    $display("FAIL stall_release: got valid=%b pc=%h inst=%h, want 1 %h %h",
                             obs_valid, obs_pc, obs_inst, exp_pc, exp_inst);
                end
            end
        end
    endtask

    task automatic test_ex_redirect();
        bit seen = 0;
        set_idle();
        lat_min = 4; lat_max = 4;
        for (int i = 0; i < 12 && pend.size() < 2; i++) tick();
        t_ex = 1; t_ex_tgt = 32'h100;
        tick();
        t_ex = 0;
        tests_run++;
        if (obs_valid !== 1'b0 || obs_req_valid !== 1'b0) begin
            failed++;
            $display("FAIL ex_cycle: got valid=%b req_valid=%b, want 0 0", obs_valid, obs_req_valid);
        end
        lat_min = 0; lat_max = 1;
        for (int i = 0; i < 25 && !seen; i++) begin
            tick();
            if (deliv) seen = 1;
        end
        tests_run++;
        if (!seen || obs_pc !== 32'h100) begin
            failed++;
            $display("FAIL ex_first_pc: got seen=%b pc=%h, want 1 00000100", seen, obs_pc);
        end
    endtask

    task automatic test_irq_ex();
        bit seen = 0;
        set_idle();
        lat_max = 2;
        for (int i = 0; i < 6; i++) tick();
        t_irq = 1; t_ex = 1; t_ex_tgt = 32'h200; t_mtvec = 32'h800; t_dev = 6'd2;
        tick();
        t_irq = 0; t_ex = 0;
        tests_run++;
        if (obs_valid !== 1'b0) begin
            failed++;
            $display("FAIL irq_valid_low: got %b, want 0", obs_valid);
        end
        tick();
        tests_run++;
        if (obs_req_addr !== 32'h810) begin
            failed++;
            $display("FAIL irq_vector: got addr=%h, want 00000810", obs_req_addr);
        end
        for (int i = 0; i < 25 && !seen; i++) begin
            if (i > 0) tick();
            if (deliv) seen = 1;
        end
        tests_run++;
        if (!seen || obs_pc !== 32'h810) begin
            failed++;
            $display("FAIL irq_first_pc: got seen=%b pc=%h, want 1 00000810", seen, obs_pc);
        end
    endtask

    task automatic test_bpu();
        bit seen = 0;
        bit ok = 0;
        set_idle();
        t_ready_if = 0; t_ex = 1; t_ex_tgt = 32'h20;
        tick();
        t_ex = 0;
        for (int i = 0; i < 10 && !ok; i++) begin
            tick();
            ok = (mq.size() > 0) && (mq[0] == 32'h20);
        end
        t_bpu = 1; t_bpu_tgt = 32'h40; t_ready_if = 1;
        tick();
        t_bpu = 0;
        tests_run++;
        if (!ok || obs_valid !== 1'b1 || obs_pc !== 32'h20) begin
            failed++;
            $display("FAIL bpu_head: got valid=%b pc=%h, want 1 00000020", obs_valid, obs_pc);
        end
        for (int i = 0; i < 25 && !seen; i++) begin
            tick();
            if (deliv) seen = 1;
        end
        tests_run++;
        if (!seen || obs_pc !== 32'h40) begin
            failed++;
            $display("FAIL bpu_target: got seen=%b pc=%h, want 1 00000040", seen, obs_pc);
        end
    endtask

    task automatic test_random();
        set_idle();
        lat_max = 3;
        for (int i = 0; i < 600; i++) begin
            t_irq       = ($urandom_range(0, 99) < 2);
            t_ex        = ($urandom_range(0, 99) < 4);
            t_bpu       = ($urandom_range(0, 99) < 15);
            t_ready_if  = ($urandom_range(0, 99) < 70);
            t_ready_mem = ($urandom_range(0, 99) < 75);
            t_ex_tgt    = {22'd0, 8'($urandom), 2'b00};
            t_bpu_tgt   = {22'd0, 8'($urandom), 2'b00};
            t_mtvec     = {$urandom} & 32'hFFFF_FFF8;
            t_dev       = 6'($urandom);
            tick();
            tests_run++;
            if (obs_valid !== exp_valid || obs_cnt != exp_cnt) begin
                failed++;
                $display("FAIL rand_valid@%0d: got valid=%b cnt=%0d, want %b %0d",
                         cyc, obs_valid, obs_cnt, exp_valid, exp_cnt);
            end
            tests_run++;
            if (obs_req_valid !== exp_req_valid || obs_req_addr !== exp_req_addr) begin
                failed++;
                $display("FAIL rand_req@%0d: got valid=%b addr=%h, want %b %h",
                         cyc, obs_req_valid, obs_req_addr, exp_req_valid, exp_req_addr);
            end
            if (deliv) begin
                tests_run++;
                if (obs_pc !== exp_pc || obs_inst !== exp_inst || obs_pc4 !== exp_pc + 32'd4) begin
                    failed++;
                    $display("FAIL rand_data@%0d: got pc=%h inst=%h pc4=%h, want %h %h %h",
                             cyc, obs_pc, obs_inst, obs_pc4, exp_pc, exp_inst, exp_pc + 32'd4);
                end
            end
        end
    endtask

    task automatic test_reset_full();
        set_idle();
        t_ready_if = 0;
        for (int i = 0; i < 10; i++) tick();
        tests_run++;
        if (obs_cnt != 4) begin
            failed++;
            $display("FAIL rstfull_fill: got cnt=%0d, want 4", obs_cnt);
        end
        do_reset();
        t_ready_mem = 0;
        tick();
        tests_run++;
        if (obs_valid !== 1'b0 || obs_cnt != 0 || obs_req_addr !== RESET_PC) begin
            failed++;
            $display("FAIL rstfull_after: got valid=%b cnt=%0d addr=%h, want 0 0 %h",
                     obs_valid, obs_cnt, obs_req_addr, RESET_PC);
        end
    endtask

    initial begin
        tests_run = 0; failed = 0; epoch = 0; cyc = 0; fetch_pc_m = RESET_PC;
        RST = 1'b1;
        PC_Control__IRQ = 0; Device_id = '0; CSR_mtvec = '0;
        Branch_Taken__EX_MEM = 0; Branch_Target_Addr__EX_MEM = '0;
        BPU__Branch_Taken = 0; BPU__Branch_Target_Addr = '0;
        IMem_Req_Ready = 0; IMem_Rsp_Valid = 0; IMem_Rsp_Data = '0; Inst_Ready__IF_ID = 0;
        set_idle();
        test_reset();
        test_stream();
        test_backpressure();
        test_ex_redirect();
        test_irq_ex();
        test_bpu();
        test_random();
        test_reset_full();
        $display("[TB] %0d tests run, %0d failed", tests_run, failed);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, want completion");
        $fatal(1, "watchdog");
    end

endmodule
